// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: reset/trap addresses, jump kinds,
// FSM states and the misaligned-target cause code.
package pc_sequencer_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] MTVEC    = 32'h0000_0100;

    localparam logic [1:0] JMP_SEQ  = 2'b00;
    localparam logic [1:0] JMP_BR   = 2'b01;
    localparam logic [1:0] JMP_JUMP = 2'b10;
    localparam logic [1:0] JMP_EXC  = 2'b11;

    localparam logic [3:0] CAUSE_MISALIGNED = 4'd0;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_TRAP_SAVE = 2'd1,
        ST_TRAP_VEC  = 2'd2
    } state_t;

endpackage

// File: rtl/pc_sequencer_next_pc_calc.sv
// Combinational branch/jump resolution: whether control leaves the sequential
// path, where it goes, and whether that target is misaligned (bit 1 set).
module next_pc_calc
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [1:0]  i_jump,
    input  logic        i_branch,
    input  logic        i_reg_sel,
    input  logic        i_cond,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_rs1,
    output logic        o_taken,
    output logic [31:0] o_target,
    output logic        o_misaligned
);

    logic [31:0] w_pc_rel;
    logic [31:0] w_reg_rel;

    assign w_pc_rel  = i_pc + i_imm;
    assign w_reg_rel = (i_rs1 + i_imm) & ~32'h1;

    always_comb begin
        o_taken  = 1'b0;
        o_target = w_pc_rel;
        if (i_jump == JMP_BR) begin
            o_taken = !i_branch || i_cond;
        end else if (i_jump == JMP_JUMP) begin
            o_taken  = 1'b1;
            o_target = i_reg_sel ? w_reg_rel : w_pc_rel;
        end
    end

    assign o_misaligned = o_taken && o_target[1];

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer with a three-state trap FSM (RUN/TRAP_SAVE/TRAP_VEC).
// Redirects land on pc one clock after the deciding cycle; stall freezes everything.
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        ctrl_valid,
    input  logic [1:0]  jump,
    input  logic        branch,
    input  logic        reg_sel,
    input  logic        cond,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    input  logic [3:0]  exc_cause,
    input  logic        mret,
    output logic [31:0] pc,
    output logic [31:0] link,
    output logic        flush,
    output logic        trap_active,
    output logic [31:0] mepc,
    output logic [3:0]  mcause
);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_mepc;
    logic [3:0]  r_mcause;
    logic        r_flush;

    logic        w_taken;
    logic [31:0] w_target;
    logic        w_misaligned;
    logic [31:0] w_link;

    assign w_link = r_pc + 32'd4;

    next_pc_calc u_next_pc_calc (
        .i_pc         (r_pc),
        .i_jump       (jump),
        .i_branch     (branch),
        .i_reg_sel    (reg_sel),
        .i_cond       (cond),
        .i_imm        (imm),
        .i_rs1        (rs1),
        .o_taken      (w_taken),
        .o_target     (w_target),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_pc     <= RESET_PC;
            r_mepc   <= 32'd0;
            r_mcause <= 4'd0;
            r_flush  <= 1'b0;
        end else if (stall) begin
            // flush marks a pc load, and no load happens while stalled
            r_flush <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (ctrl_valid) begin
                        if (jump == JMP_EXC) begin
                            r_mepc   <= r_pc;
                            r_mcause <= exc_cause;
                            r_state  <= ST_TRAP_SAVE;
                        end else if (mret) begin
                            r_pc    <= r_mepc;
                            r_flush <= 1'b1;
                        end else if (w_misaligned) begin
                            r_mepc   <= r_pc;
                            r_mcause <= CAUSE_MISALIGNED;
                            r_state  <= ST_TRAP_SAVE;
                        end else if (w_taken) begin
                            r_pc    <= w_target;
                            r_flush <= 1'b1;
                        end else begin
                            r_pc <= w_link;
                        end
                    end
                end
                ST_TRAP_SAVE: begin
                    r_state <= ST_TRAP_VEC;
                end
                ST_TRAP_VEC: begin
                    r_pc    <= MTVEC;
                    r_flush <= 1'b1;
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign pc          = r_pc;
    assign link        = w_link;
    assign flush       = r_flush;
    assign trap_active = (r_state != ST_RUN);
    assign mepc        = r_mepc;
    assign mcause      = r_mcause;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed checks of the sequencer scenarios followed by randomized traffic,
// all compared each cycle against a reference model of the architectural rules.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst, stall, ctrl_valid, branch, reg_sel, cond, mret;
    logic [1:0]  jump;
    logic [31:0] imm, rs1;
    logic [3:0]  exc_cause;
    logic [31:0] pc, link, mepc;
    logic        flush, trap_active;
    logic [3:0]  mcause;

    int n_tests = 0;
    int n_fail  = 0;

    // reference state: trap_left counts the clocks still needed to reach MTVEC
    logic [31:0] m_pc, m_mepc;
    logic [3:0]  m_mcause;
    logic        m_flush;
    int          trap_left;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .stall(stall), .ctrl_valid(ctrl_valid),
        .jump(jump), .branch(branch), .reg_sel(reg_sel), .cond(cond),
        .imm(imm), .rs1(rs1), .exc_cause(exc_cause), .mret(mret),
        .pc(pc), .link(link), .flush(flush), .trap_active(trap_active),
        .mepc(mepc), .mcause(mcause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic cv, input logic [1:0] j, input logic br,
                          input logic rs, input logic cd, input logic [31:0] im,
                          input logic [31:0] r1, input logic [3:0] cause, input logic mr);
        ctrl_valid = cv; jump = j; branch = br; reg_sel = rs; cond = cd;
        imm = im; rs1 = r1; exc_cause = cause; mret = mr;
    endtask

    task automatic model_step();
        logic        taken;
        logic [31:0] tgt;
        if (rst) begin
            m_pc = 32'h0; m_mepc = 32'h0; m_mcause = 4'h0; m_flush = 1'b0; trap_left = 0;
        end else if (stall) begin
            m_flush = 1'b0;
        end else if (trap_left == 2) begin
            trap_left = 1; m_flush = 1'b0;
        end else if (trap_left == 1) begin
            trap_left = 0; m_pc = 32'h100; m_flush = 1'b1;
        end else begin
            m_flush = 1'b0;
            if (ctrl_valid) begin
                taken = (jump == 2'd2) || (jump == 2'd1 && (!branch || cond));
                tgt   = (jump == 2'd2 && reg_sel) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (m_pc + imm);
                if (jump == 2'd3) begin
                    m_mepc = m_pc; m_mcause = exc_cause; trap_left = 2;
                end else if (mret) begin
                    m_pc = m_mepc; m_flush = 1'b1;
                end else if (taken && tgt[1]) begin
                    m_mepc = m_pc; m_mcause = 4'd0; trap_left = 2;
                end else if (taken) begin
                    m_pc = tgt; m_flush = 1'b1;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    // one clock: model advances on the pre-edge inputs, outputs sampled 1ns later
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("pc", pc, m_pc);
        chk("link", link, m_pc + 32'd4);
        chk("flush", {31'd0, flush}, {31'd0, m_flush});
        chk("trap_active", {31'd0, trap_active}, {31'd0, (trap_left != 0)});
        chk("mepc", mepc, m_mepc);
        chk("mcause", {28'd0, mcause}, {28'd0, m_mcause});
    endtask

    task automatic goto_pc(input logic [31:0] addr);
        set_in(1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 32'd0, addr, 4'd0, 1'b0);
        tick();
        set_in(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0;
        set_in(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
        m_pc = 32'hx; m_mepc = 32'hx; m_mcause = 4'hx; m_flush = 1'bx; trap_left = 0;
        @(negedge clk);
        tick();
        tick();
        chk("reset_pc", pc, 32'h0);

        // sequential fetch from reset
        rst = 1'b0;
        set_in(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
        tick(); chk("seq_4", pc, 32'h4);
        tick(); chk("seq_8", pc, 32'h8);
        tick(); chk("seq_12", pc, 32'hC);

        // conditional branch not taken, then taken
        goto_pc(32'h40);
        set_in(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 32'h20, 32'd0, 4'd0, 1'b0);
        tick(); chk("br_not_taken", pc, 32'h44); chk("br_nt_flush", {31'd0, flush}, 32'd0);
        goto_pc(32'h40);
        set_in(1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 32'h20, 32'd0, 4'd0, 1'b0);
        tick(); chk("br_taken", pc, 32'h60); chk("br_t_flush", {31'd0, flush}, 32'd1);
        set_in(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
        tick(); chk("flush_drop", {31'd0, flush}, 32'd0);

        // JALR clears bit 0; bit 1 set traps as misaligned
        goto_pc(32'h10);
        set_in(1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 32'd0, 32'h201, 4'd0, 1'b0);
        tick(); chk("jalr", pc, 32'h200);
        goto_pc(32'h10);
        set_in(1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 32'd0, 32'h202, 4'd0, 1'b0);
        tick(); chk("mis_mepc", mepc, 32'h10); chk("mis_cause", {28'd0, mcause}, 32'd0);
        chk("mis_trap", {31'd0, trap_active}, 32'd1); chk("mis_hold", pc, 32'h10);
        set_in(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
        tick(); tick(); chk("mis_vec", pc, 32'h100);

        // explicit exception then mret
        goto_pc(32'h80);
        set_in(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd2, 1'b0);
        tick(); chk("exc_ta1", {31'd0, trap_active}, 32'd1);
        set_in(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
        tick(); chk("exc_ta2", {31'd0, trap_active}, 32'd1); chk("exc_pc_hold", pc, 32'h80);
        tick(); chk("exc_vec", pc, 32'h100); chk("exc_ta_off", {31'd0, trap_active}, 32'd0);
        chk("exc_mepc", mepc, 32'h80); chk("exc_cause", {28'd0, mcause}, 32'd2);
        set_in(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
        tick(); chk("mret", pc, 32'h80); chk("mret_flush", {31'd0, flush}, 32'd1);

        // stall through TRAP_SAVE, then reset in TRAP_VEC
        goto_pc(32'h80);
        set_in(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd5, 1'b0);
        tick();
        set_in(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("stall_pc", pc, 32'h80); chk("stall_ta", {31'd0, trap_active}, 32'd1);
        stall = 1'b0;
        tick();
        rst = 1'b1;
        tick(); chk("rst_vec_pc", pc, 32'h0); chk("rst_vec_ta", {31'd0, trap_active}, 32'd0);
        rst = 1'b0;

        // address wrap
        goto_pc(32'hFFFF_FFFC);
        set_in(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
        tick(); chk("wrap", pc, 32'h0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 99) < 2);
            stall = ($urandom_range(0, 99) < 15);
            set_in($urandom_range(0, 99) < 80, 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)),
                   32'(int'($urandom_range(0, 255)) * 2 - 256),
                   $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 99) < 10);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 RESET_PC, 32'h0000_0000, PC loaded by reset.
REQ-002 MTVEC, 32'h0000_0100, trap vector address.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall  input  1  hold PC and all state when high; rst has priority over stall.
REQ-006 ctrl_valid  input  1  jump/branch/reg_sel/cond/imm/rs1 describe the instruction at pc this cycle.
REQ-007 jump  input  2  00 sequential, 01 conditional branch, 10 unconditional jump, 11 exception.
REQ-008 branch  input  1  with jump=01: 1 = taken only if cond, 0 = always taken.
REQ-009 reg_sel  input  1  with jump=10: 1 = target rs1+imm (JALR), 0 = pc+imm (JAL).
REQ-010 cond  input  1  branch comparison result from ALU flags.
REQ-011 imm, rs1  input  32 each  sign-extended offset; register operand.
REQ-012 exc_cause  input  4  cause code, sampled when jump=11.
REQ-013 mret  input  1  return from trap, valid with ctrl_valid.
REQ-014 pc  output  32  address of current instruction.
REQ-015 link  output  32  pc+4, combinational, for rd write on jumps.
REQ-016 flush  output  1  one-cycle pulse after any redirect; kills younger fetch.
REQ-017 trap_active  output  1  high while FSM is not in RUN.
REQ-018 mepc, mcause  output  32, 4  saved trap PC and cause.

Function
REQ-019 FSM states RUN, TRAP_SAVE, TRAP_VEC; reset state RUN.
REQ-020 RUN, ctrl_valid=0 or stall=1: pc holds.
REQ-021 RUN, ctrl_valid, jump=00: pc <= pc+4 next cycle, flush=0.
REQ-022 jump=01: taken (branch=0, or branch=1 and cond=1) -> pc <= pc+imm; not taken -> pc <= pc+4.
REQ-023 jump=10: pc <= reg_sel ? ((rs1+imm) & ~32'h1) : pc+imm.
REQ-024 All adds 32-bit modulo 2^32, wrap silently.
REQ-025 Taken target with bit 1 set: no redirect; treated as exception, cause 4'd0, mepc = pc of the jump instruction.
REQ-026 jump=11 or REQ-025: RUN -> TRAP_SAVE; mepc <= pc, mcause <= exc_cause (or 0); pc holds.
REQ-027 TRAP_SAVE -> TRAP_VEC unconditionally next non-stalled cycle; TRAP_VEC: pc <= MTVEC, -> RUN.
REQ-028 ctrl_valid ignored in TRAP_SAVE and TRAP_VEC.
REQ-029 mret in RUN: pc <= mepc; mret has priority over jump=00/01/10 but not over jump=11.
REQ-030 flush=1 for exactly the cycle after pc loads a non-sequential value (taken branch, jump, MTVEC, mepc).
REQ-031 Latency: redirect visible on pc one clock after the deciding cycle; trap entry to pc=MTVEC takes 3 clocks.
REQ-032 Trap during stall: state and mepc frozen until stall drops.

Reset
REQ-033 On rst: pc=RESET_PC, state RUN, flush=0, trap_active=0, mepc=0, mcause=0.
REQ-034 rst mid-trap aborts trap; no partial mepc/mcause update that cycle.

Structure
REQ-035 jump encodings, FSM state encodings, cause 0 (misaligned) constant in shared risc-v defines include.
REQ-036 One sub-module, next_pc_calc: combinational target/taken/misaligned computation; FSM and registers in pc_sequencer.

Verification
REQ-037 Reset, then 3 cycles jump=00 -> pc 0,4,8,12; flush always 0.
REQ-038 pc=0x40, jump=01, branch=1, cond=0, imm=0x20 -> pc=0x44; repeat with cond=1 -> pc=0x60, flush=1 one cycle.
REQ-039 pc=0x10, jump=10, reg_sel=1, rs1=0x201, imm=0 -> pc=0x200; rs1=0x202 -> trap, mcause=0, mepc=0x10.
REQ-040 pc=0x80, jump=11, exc_cause=2 -> trap_active 2 cycles, mepc=0x80, mcause=2, pc=0x100; then mret -> pc=0x80.
REQ-041 stall held 4 cycles during TRAP_SAVE -> pc and state frozen; rst asserted in TRAP_VEC -> pc=RESET_PC, RUN.
REQ-042 pc=0xFFFF_FFFC, jump=00 -> pc=0x0 (wrap).
